// File: rtl/srl_fifo_pkg.sv
// Shared types and elaboration helpers for the SRL-backed first-word-fall-through FIFO.
package srl_fifo_pkg;

    typedef enum logic {
        OutIdle  = 1'b0,
        OutValid = 1'b1
    } out_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Every SRL entry must be reachable through the read address.
    function automatic bit depth_fits(input int unsigned depth, input int unsigned addr_width);
        return (depth > 0) && (clog2(depth) <= addr_width);
    endfunction

endpackage

// File: rtl/srl_fifo_storage.sv
// Shift-register storage: a write shifts every entry up by one and loads din into entry 0.
module srl_fifo_storage #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// FWFT FIFO controller: sequences the SRL storage and owns a registered output stage,
// giving DEPTH + 1 words of capacity behind a full_n / empty_n handshake.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  flush,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    if (!depth_fits(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
        $error("srl_fifo_ctrl: DEPTH does not fit in 2**ADDR_WIDTH entries");
    end

    logic [CntW-1:0]       srl_cnt_q, srl_cnt_d, cnt_m1;
    out_state_e            out_state_q, out_state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d, srl_dout;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic                  push, pop, load, out_valid;

    assign out_valid = (out_state_q == OutValid);
    assign if_full_n = (srl_cnt_q != CntFull);
    assign push      = if_write & if_full_n & ~flush;
    assign pop       = if_read & out_valid;
    assign load      = (srl_cnt_q != '0) & (~out_valid | pop);

    // The read happens before the shift, so the oldest entry sits at srl_cnt - 1.
    assign cnt_m1    = srl_cnt_q - CntW'(1);
    assign srl_addr  = (srl_cnt_q == '0) ? '0 : cnt_m1[ADDR_WIDTH-1:0];

    srl_fifo_storage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_storage (
        .clk_i (ap_clk),
        .we_i  (push),
        .addr_i(srl_addr),
        .din_i (if_din),
        .dout_o(srl_dout)
    );

    always_comb begin
        srl_cnt_d   = srl_cnt_q;
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        if (flush) begin
            srl_cnt_d   = '0;
            out_state_d = OutIdle;
        end else begin
            srl_cnt_d = srl_cnt_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, load};
            if (load) begin
                out_state_d = OutValid;
                out_data_d  = srl_dout;
            end else if (pop) begin
                out_state_d = OutIdle;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            srl_cnt_q   <= '0;
            out_state_q <= OutIdle;
            out_data_q  <= '0;
        end else begin
            srl_cnt_q   <= srl_cnt_d;
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
        end
    end

    assign if_empty_n = out_valid;
    assign if_dout    = out_data_q;
    assign count      = srl_cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid};

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard bench for srl_fifo_ctrl: accepted pushes are queued, pops are checked against
// the queue head, and handshake/occupancy outputs are compared every cycle.
module tb_srl_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          flush;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   count;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    logic [DW-1:0] sb_q [$];
    int            srl_n;
    bit            ov;

    always #5 ap_clk = ~ap_clk;

    srl_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .flush     (flush),
        .if_write  (if_write),
        .if_din    (if_din),
        .if_full_n (if_full_n),
        .if_read   (if_read),
        .if_dout   (if_dout),
        .if_empty_n(if_empty_n),
        .count     (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        srl_n = 0;
        ov    = 1'b0;
        sb_q.delete();
    endtask

    // One clock cycle: check outputs and drive inputs at the falling edge, advance model after
    // the rising edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit fl);
        bit push, pop, load;
        @(negedge ap_clk);
        check_eq("empty_n", 32'(if_empty_n), 32'(ov));
        check_eq("full_n", 32'(if_full_n), 32'(srl_n != DEPTH));
        check_eq("count", 32'(count), 32'(srl_n) + 32'(ov));
        if (ov) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: output valid but no word expected at %0t", $time);
            end else begin
                check_eq("dout", 32'(if_dout), 32'(sb_q[0]));
            end
        end
        push     = w && (srl_n != DEPTH);
        pop      = r && ov;
        if_write = w;
        if_din   = d;
        if_read  = r;
        flush    = fl;
        @(posedge ap_clk);
        if (fl) begin
            model_clear();
        end else begin
            load = (srl_n != 0) && (!ov || pop);
            if (pop) void'(sb_q.pop_front());
            if (load) begin
                srl_n--;
                ov = 1'b1;
            end else if (pop) begin
                ov = 1'b0;
            end
            if (push) begin
                srl_n++;
                sb_q.push_back(d);
            end
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_empty_n"}, 32'(if_empty_n), 32'd0);
        check_eq({pfx, "_full_n"}, 32'(if_full_n), 32'd1);
        check_eq({pfx, "_count"}, 32'(count), 32'd0);
        check_eq({pfx, "_dout"}, 32'(if_dout), 32'd0);
    endtask

    initial begin
        ap_rst_n = 1'b1;
        flush    = 1'b0;
        if_write = 1'b0;
        if_din   = '0;
        if_read  = 1'b0;
        model_clear();
        #2 ap_rst_n = 1'b0;
        #2 check_reset_values("rst");
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Idle with reads while empty: nothing may change.
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Single push: visible two edges later.
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        #1 check_eq("lat_early_empty_n", 32'(if_empty_n), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        #1 check_eq("lat_empty_n", 32'(if_empty_n), 32'd1);
        check_eq("lat_dout", 32'(if_dout), 32'h01);
        cyc(1'b0, '0, 1'b1, 1'b0);
        #1 check_eq("pop1_count", 32'(count), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Fill to DEPTH+1, the sixth push must be ignored.
        for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        #1 check_eq("fill_count", 32'(count), 32'd5);
        check_eq("fill_full_n", 32'(if_full_n), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        #1 check_eq("drain_count", 32'(count), 32'd0);

        // Prime with two words, then stream one push and one pop per cycle.
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
        #1 check_eq("stream_count", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush with three words queued and a concurrent push.
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h23, 1'b0, 1'b0);
        #1 check_eq("preflush_count", 32'(count), 32'd3);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        #1 check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_empty_n", 32'(if_empty_n), 32'd0);
        check_eq("flush_full_n", 32'(if_full_n), 32'd1);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        #1 check_eq("postflush_dout", 32'(if_dout), 32'h55);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream for half a cycle.
        cyc(1'b1, 8'h31, 1'b0, 1'b0);
        cyc(1'b1, 8'h32, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        if_write = 1'b0;
        if_read  = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1 check_reset_values("arst");
        #4 ap_rst_n = 1'b1;
        model_clear();
        cyc(1'b1, 8'h0A, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        #1 check_eq("arst_first_dout", 32'(if_dout), 32'h0A);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/srl_fifo_ctrl.md
Name: srl_fifo_ctrl

Overview:
- Controller that sequences a shift-register (SRL) storage array as a first-word-fall-through FIFO for inter-stage stream and start-token channels.
- Generates the shift enable and read address for the storage, and tracks occupancy.
- Adds one registered output stage and exposes a full_n / empty_n handshake to producer and consumer.
- Sits between an upstream task's start/data output and a downstream PE's input.

Parameters:
- DATA_WIDTH, 1, payload width.
- ADDR_WIDTH, 2, storage address width; DEPTH <= 2**ADDR_WIDTH required (elaboration error otherwise).
- DEPTH, 4, SRL entries; total capacity = DEPTH + 1 (SRL plus output register).

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of occupancy; data contents untouched.
- if_write  in  1  producer push request.
- if_din  in  DATA_WIDTH  push data.
- if_full_n  out  1  high = SRL can accept a push this cycle.
- if_read  in  1  consumer pop request.
- if_dout  out  DATA_WIDTH  head data (output register).
- if_empty_n  out  1  high = if_dout valid.
- count  out  ADDR_WIDTH+1  total occupancy (srl_cnt + out_valid).

Behaviour:
- State: srl_cnt (0..DEPTH), out_valid (FSM OUT_IDLE / OUT_VALID), out_data.
- Reset (ap_rst_n low, async): srl_cnt=0, out_valid=0 (OUT_IDLE), out_data=0.
  - Outputs during and after reset: if_empty_n=0, if_full_n=1, count=0, if_dout=0.
  - SRL contents are not reset.
- push = if_write & if_full_n; writes while full are ignored, with no state change.
- pop = if_read & if_empty_n; reads while empty are ignored.
- if_full_n = (srl_cnt != DEPTH), combinational from registered srl_cnt.
- if_empty_n = out_valid.
- Storage interface (srl_fifo_storage sub-module):
  - we = push; shift entry i to i+1, din into entry 0.
  - addr = srl_cnt-1, forced to 0 when srl_cnt = 0.
- load = (srl_cnt != 0) & (!out_valid | pop). On load: out_data <= storage dout (pre-shift read, oldest entry); out_valid <= 1.
- pop without load: out_valid <= 0 (OUT_VALID -> OUT_IDLE).
- srl_cnt_next = srl_cnt + push - load; simultaneous push and load leaves srl_cnt unchanged, and addr stays correct because the read precedes the shift.
- Latency: push into an empty FIFO at cycle t -> if_empty_n=1 with that data at t+2.
- Throughput: one push and one pop per cycle sustained, with no bubbles once primed.
- Order: strict FIFO, with no loss or duplication under any push/pop interleaving.
- flush: next cycle srl_cnt=0 and out_valid=0. It has priority over push, pop and load in the same cycle; a push coinciding with flush is dropped.
- Reset asserted mid-operation: immediate return to reset values; queued data is discarded.
- count never exceeds DEPTH+1 and never wraps.

Decomposition:
- Shared package srl_fifo_pkg:
  - occupancy width function clog2 helper.
  - OUT_IDLE/OUT_VALID state encoding (1 bit).
  - Elaboration check DEPTH <= 2**ADDR_WIDTH.
- One sub-module, srl_fifo_storage: pure SRL array (we, addr, din, dout), no reset.
  - Instantiated once; this block holds all control.

Test Plan:
- Reset then idle -> if_empty_n=0, if_full_n=1, count=0; pulse if_read, no state change.
- Single push 0x1 at cycle t -> if_empty_n=1, if_dout=0x1 at t+2; pop -> count=0, empty_n=0 next cycle.
- Five pushes 1..5 with no reads (DEPTH=4) -> count=5, if_full_n=0 after 4th SRL fill; sixth push ignored; pops return 1,2,3,4,5 in order.
- Continuous simultaneous push/pop for 100 cycles after priming with 2 entries -> count stays 2, output sequence matches input, no bubbles.
- flush asserted with count=3 and concurrent push -> next cycle count=0, empty_n=0, full_n=1; pushed word never appears.
- ap_rst_n pulled low mid-stream for half a cycle (async) -> outputs return to reset values immediately; post-reset push 0xA emerges first.
